// File: rtl/trena_agendador.sv
// Measurement scheduler for the trena control unit: manual/periodic start, timeout abort, error hold.
// Optional macro TRENA_AGENDADOR_RETRY_EN re-issues aborted measurements up to MAX_TENT attempts.
module trena_agendador #(
  parameter int PERIODO  = 50_000_000,
  parameter int TIMEOUT  = 2_500_000,
  parameter int MAX_TENT = 3
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       mensurar_i,
  input  logic       modo_auto_i,
  input  logic       pronto_trena_i,
  output logic       inicia_trena_o,
  output logic       reset_trena_o,
  output logic       ocupado_o,
  output logic       pronto_o,
  output logic       erro_o,
  output logic [1:0] tentativas_o,
  output logic [3:0] db_estado_o
);

  localparam int PW = (PERIODO > 1) ? $clog2(PERIODO) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PW-1:0] PER_LAST = PW'(PERIODO - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [1:0]    MAX_T    = 2'(MAX_TENT);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    ESPERA_PERIODO = 4'h1,
    DISPARA        = 4'h2,
    AGUARDA        = 4'h3,
    ABORTA         = 4'h4,
    ERRO           = 4'hE,
    FIM            = 4'hF
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [PW-1:0] cnt_per_q, cnt_per_d;
  logic [TW-1:0] cnt_to_q, cnt_to_d;
  logic [1:0]    tent_q, tent_d;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      estado_q  <= INICIAL;
      cnt_per_q <= '0;
      cnt_to_q  <= '0;
      tent_q    <= '0;
    end else begin
      estado_q  <= estado_d;
      cnt_per_q <= cnt_per_d;
      cnt_to_q  <= cnt_to_d;
      tent_q    <= tent_d;
    end
  end

  // Counters fall back to zero outside their own state, so each entry starts clean.
  always_comb begin
    estado_d  = estado_q;
    cnt_per_d = '0;
    cnt_to_d  = '0;
    tent_d    = tent_q;
    case (estado_q)
      INICIAL: begin
        if (mensurar_i || modo_auto_i) estado_d = DISPARA;
      end
      ESPERA_PERIODO: begin
        if (mensurar_i)                estado_d = DISPARA;
        else if (!modo_auto_i)         estado_d = INICIAL;
        else if (cnt_per_q == PER_LAST) estado_d = DISPARA;
        else                           cnt_per_d = cnt_per_q + PW'(1);
      end
      DISPARA: begin
        estado_d = AGUARDA;
      end
      AGUARDA: begin
        if (pronto_trena_i)            estado_d = FIM;
        else if (cnt_to_q == TO_LAST)  estado_d = ABORTA;
        else                           cnt_to_d = cnt_to_q + TW'(1);
      end
      ABORTA: begin
        if (tent_q != MAX_T) tent_d = tent_q + 2'd1;
`ifdef TRENA_AGENDADOR_RETRY_EN
        if (int'(tent_q) + 1 < MAX_TENT) estado_d = DISPARA;
        else                             estado_d = ERRO;
`else
        estado_d = ERRO;
`endif
      end
      FIM: begin
        tent_d   = '0;
        estado_d = modo_auto_i ? ESPERA_PERIODO : INICIAL;
      end
      ERRO: begin
        if (mensurar_i) begin
          estado_d = DISPARA;
          tent_d   = '0;
        end
      end
      default: estado_d = INICIAL;
    endcase
  end

  assign inicia_trena_o = (estado_q == DISPARA);
  assign reset_trena_o  = (estado_q == ABORTA);
  assign ocupado_o      = (estado_q == DISPARA) || (estado_q == AGUARDA) || (estado_q == ABORTA);
  assign pronto_o       = (estado_q == FIM);
  assign erro_o         = (estado_q == ERRO);
  assign tentativas_o   = tent_q;
  assign db_estado_o    = estado_q;

endmodule
